sram_arbiter: RTL

- Two-requester round-robin arbiter and sequencer in front of the SRAM controller's AHB-style slave port (haddr/hwrite/hwdata in, hready/hrdata out).
- Accepts one single-beat read or write per grant and drives the address phase for exactly one cycle.
- Waits for hready, returns read data and a done pulse to the winning requester, and aborts with an error if hready never arrives.
- Sits between the two bus masters and the SRAM controller.

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_arbiter_if.sv | 57 +++++
 rtl/rr_arb2.sv | 28 ++
 rtl/sram_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared definitions for the two-requester SRAM arbiter:
//   state_t    - sequencer states (IDLE, ADDR, DATA, RESP)
//   REQ0/REQ1  - requester index encodings used for winner/last_grant
//   CNT_WIDTH  - width of the saturating DATA-state wait counter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles both requester ports and the downstream SRAM-controller port.
//   m0_* / m1_* : req, addr, write, wdata (towards arbiter)
//                 grant, done, err, rdata (from arbiter)
//   s_*         : hvalid, haddr, hwrite, hwdata (from arbiter)
//                 hready, hrdata (towards arbiter)
// Modports:
//   slave  - the arbiter's view (serves the requesters, drives the SRAM side)
//   master - the surrounding system's view (requesters plus SRAM controller)
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 8
);
    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_write;
    logic [WORD_WIDTH-1:0] m0_wdata;
    logic                  m0_grant;
    logic                  m0_done;
    logic                  m0_err;
    logic [WORD_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_write;
    logic [WORD_WIDTH-1:0] m1_wdata;
    logic                  m1_grant;
    logic                  m1_done;
    logic                  m1_err;
    logic [WORD_WIDTH-1:0] m1_rdata;

    logic                  s_hvalid;
    logic [ADDR_WIDTH-1:0] s_haddr;
    logic                  s_hwrite;
    logic [WORD_WIDTH-1:0] s_hwdata;
    logic                  s_hready;
    logic [WORD_WIDTH-1:0] s_hrdata;

    modport slave (
        input  m0_req, m0_addr, m0_write, m0_wdata,
        output m0_grant, m0_done, m0_err, m0_rdata,
        input  m1_req, m1_addr, m1_write, m1_wdata,
        output m1_grant, m1_done, m1_err, m1_rdata,
        output s_hvalid, s_haddr, s_hwrite, s_hwdata,
        input  s_hready, s_hrdata
    );

    modport master (
        output m0_req, m0_addr, m0_write, m0_wdata,
        input  m0_grant, m0_done, m0_err, m0_rdata,
        output m1_req, m1_addr, m1_write, m1_wdata,
        input  m1_grant, m1_done, m1_err, m1_rdata,
        input  s_hvalid, s_haddr, s_hwrite, s_hwdata,
        output s_hready, s_hrdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin pick.
//   req0, req1  : requests
//   last_grant  : index of the previously granted requester (owned by caller)
//   winner      : chosen requester index
//   valid       : at least one request present
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    // On contention the requester that did not win last time goes next.
    always_comb begin
        valid  = req0 | req1;
        winner = REQ0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = REQ1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Round-robin arbiter and single-beat sequencer in front of an AHB-style
// SRAM controller slave port.
//   hclk   : clock
//   hreset : asynchronous active-high reset
//   bus    : sram_arbiter_if.slave (two requester ports + SRAM port)
// Each grant issues one address-phase cycle, waits for s_hready (bounded by
// TIMEOUT_CYCLES DATA cycles) and answers the winner with a done pulse.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int WORD_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
)(
    input  logic           hclk,
    input  logic           hreset,
    sram_arbiter_if.slave  bus
);

    localparam logic [CNT_WIDTH:0] TIMEOUT_LIMIT = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);

    state_t                state;
    state_t                state_next;
    logic                  cur_idx;
    logic                  last_grant;
    logic                  err_q;
    logic                  hold_write;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [WORD_WIDTH-1:0] hold_wdata;
    logic [WORD_WIDTH-1:0] m0_rdata_q;
    logic [WORD_WIDTH-1:0] m1_rdata_q;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic                  arb_winner;
    logic                  arb_valid;
    logic                  timeout_hit;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.m0_req),
        .req1       (bus.m1_req),
        .last_grant (last_grant),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    // True in the DATA cycle whose miss would bring the count to the limit;
    // s_hready in that same cycle still wins because it is checked first.
    assign timeout_hit = (({1'b0, wait_cnt} + (CNT_WIDTH+1)'(1)) >= TIMEOUT_LIMIT);

    assign bus.s_haddr  = hold_addr;
    assign bus.s_hwrite = hold_write;
    assign bus.s_hwdata = hold_wdata;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_next   = state;
        bus.s_hvalid = 1'b0;
        bus.m0_grant = 1'b0;
        bus.m1_grant = 1'b0;
        bus.m0_done  = 1'b0;
        bus.m1_done  = 1'b0;
        bus.m0_err   = 1'b0;
        bus.m1_err   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                state_next   = DATA;
                bus.s_hvalid = 1'b1;
                bus.m0_grant = (cur_idx == REQ0);
                bus.m1_grant = (cur_idx == REQ1);
            end
            DATA: begin
                if (bus.s_hready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next  = IDLE;
                bus.m0_done = (cur_idx == REQ0);
                bus.m1_done = (cur_idx == REQ1);
                bus.m0_err  = (cur_idx == REQ0) && err_q;
                bus.m1_err  = (cur_idx == REQ1) && err_q;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding registers, wait counter, outcome flag and per-requester read
    // data. Requester inputs are only looked at in IDLE, so later changes on
    // req/addr/data cannot disturb a transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cur_idx    <= REQ0;
            last_grant <= REQ1;
            err_q      <= 1'b0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        cur_idx    <= arb_winner;
                        last_grant <= arb_winner;
                        err_q      <= 1'b0;
                        wait_cnt   <= '0;
                        if (arb_winner == REQ0) begin
                            hold_addr  <= bus.m0_addr;
                            hold_write <= bus.m0_write;
                            hold_wdata <= bus.m0_wdata;
                        end else begin
                            hold_addr  <= bus.m1_addr;
                            hold_write <= bus.m1_write;
                            hold_wdata <= bus.m1_wdata;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_hready) begin
                        err_q <= 1'b0;
                        if (!hold_write) begin
                            if (cur_idx == REQ0) begin
                                m0_rdata_q <= bus.s_hrdata;
                            end else begin
                                m1_rdata_q <= bus.s_hrdata;
                            end
                        end
                    end else begin
                        if (wait_cnt != {CNT_WIDTH{1'b1}}) begin
                            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                        end
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
